// File: rtl/dd_adpcm_pkg.sv
// Shared constants and tables for the MSM5205-style ADPCM voice.
// Optional build macro: DD_ADPCM_MUTE_ON_STOP_EN (forces snd to 0 while idle).
package dd_adpcm_pkg;

    localparam int unsigned SIG_W    = 12;
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned STEP_W   = 11;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DIV_W    = 6;
    localparam int unsigned IDX_MAX  = 48;
    localparam int unsigned DIV_WRAP = 47;

    // CPU register map (A[2:1])
    localparam logic [1:0] REG_START = 2'd0;
    localparam logic [1:0] REG_END   = 2'd1;
    localparam logic [1:0] REG_ADDR  = 2'd2;
    localparam logic [1:0] REG_STOP  = 2'd3;

    // Playback state: idle, or which nibble of the current byte comes next
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } play_state_e;

    localparam logic [STEP_W-1:0] STEP [0:IDX_MAX] = '{
        11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,
        11'd31,   11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,
        11'd60,   11'd66,   11'd73,   11'd80,   11'd88,   11'd97,   11'd107,
        11'd118,  11'd130,  11'd143,  11'd157,  11'd173,  11'd190,  11'd209,
        11'd230,  11'd253,  11'd279,  11'd307,  11'd337,  11'd371,  11'd408,
        11'd449,  11'd494,  11'd544,  11'd598,  11'd658,  11'd724,  11'd796,
        11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411, 11'd1552
    };

    localparam logic signed [IDX_W+1:0] ADJ [0:7] = '{
        -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
    };

    // Magnitude of one ADPCM step: s/8 plus the nibble-weighted fractions of s
    function automatic logic [SIG_W-1:0] step_delta(input logic [STEP_W-1:0] s,
                                                    input logic [2:0]        mag);
        logic [SIG_W-1:0] d;
        d = SIG_W'(s >> 3);
        if (mag[0]) d = d + SIG_W'(s >> 2);
        if (mag[1]) d = d + SIG_W'(s >> 1);
        if (mag[2]) d = d + SIG_W'(s);
        return d;
    endfunction

endpackage

// File: rtl/dd_adpcm_decoder.sv
// ADPCM nibble decoder: holds the signal accumulator and step index with saturation.
module dd_adpcm_decoder
    import dd_adpcm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [3:0]              nibble,
    output logic signed [SIG_W-1:0] snd
);

    localparam logic signed [SIG_W+1:0] SIG_HI = (SIG_W+2)'(2047);
    localparam logic signed [SIG_W+1:0] SIG_LO = (SIG_W+2)'(-2048);
    localparam logic signed [IDX_W+1:0] IDX_HI = (IDX_W+2)'(IDX_MAX);
    localparam logic signed [IDX_W+1:0] IDX_LO = '0;

    logic [IDX_W-1:0]          idx;
    logic [STEP_W-1:0]         step_c;
    logic [SIG_W-1:0]          delta_c;
    logic signed [SIG_W+1:0]   ext_sig_c;
    logic signed [SIG_W+1:0]   ext_d_c;
    logic signed [SIG_W+1:0]   sum_c;
    logic signed [IDX_W+1:0]   idx_sum_c;
    logic signed [SIG_W-1:0]   sig_nx_c;
    logic [IDX_W-1:0]          idx_nx_c;

    // Next signal and step index for the presented nibble, both clamped
    always_comb begin
        step_c    = STEP[idx];
        delta_c   = step_delta(step_c, nibble[2:0]);
        ext_sig_c = (SIG_W+2)'(snd);
        ext_d_c   = $signed((SIG_W+2)'(delta_c));
        sum_c     = nibble[3] ? (ext_sig_c - ext_d_c) : (ext_sig_c + ext_d_c);
        idx_sum_c = $signed({2'b00, idx}) + ADJ[nibble[2:0]];

        if (sum_c > SIG_HI)      sig_nx_c = SIG_W'(SIG_HI);
        else if (sum_c < SIG_LO) sig_nx_c = SIG_W'(SIG_LO);
        else                     sig_nx_c = SIG_W'(sum_c);

        if (idx_sum_c < IDX_LO)      idx_nx_c = '0;
        else if (idx_sum_c > IDX_HI) idx_nx_c = IDX_W'(IDX_HI);
        else                         idx_nx_c = IDX_W'(idx_sum_c);
    end

    // Accumulator registers; clear has priority over a decode step
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            snd <= '0;
            idx <= '0;
        end else if (en) begin
            snd <= sig_nx_c;
            idx <= idx_nx_c;
        end
    end

endmodule

// File: rtl/dd_adpcm_player.sv
// One ADPCM voice: CPU register file, ROM address pointer, sample-rate divider and nibble sequencing.
// Optional build macro: DD_ADPCM_MUTE_ON_STOP_EN (snd forced to 0 whenever rom_cs is low).
module dd_adpcm_player
    import dd_adpcm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_cen,
    input  logic                    cen_oki,
    input  logic [7:0]              cpu_dout,
    input  logic [1:0]              cpu_AB,
    input  logic                    cs,
    output logic [ADDR_W-1:0]       rom_addr,
    output logic                    rom_cs,
    input  logic [7:0]              rom_data,
    input  logic                    rom_ok,
    output logic signed [SIG_W-1:0] snd,
    output logic                    sample
);

    play_state_e             state, state_nx;
    logic [ADDR_W-1:0]       end_addr;
    logic [ADDR_W-1:0]       addr_nx;
    logic [ADDR_W-1:0]       end_nx;
    logic [7:0]              byte_q, byte_nx;
    logic [DIV_W-1:0]        div;
    logic                    tick_c;
    logic                    wr_c;
    logic                    dec_en;
    logic                    dec_clr;
    logic [3:0]              nibble_c;
    logic [ADDR_W-1:0]       wr_addr_c;
    logic signed [SIG_W-1:0] dec_snd;

    assign tick_c    = cen_oki && (div == DIV_W'(DIV_WRAP));
    assign wr_c      = cs && cpu_cen;
    assign wr_addr_c = {cpu_dout[6:0], 9'd0};

    // Next-state: tick-driven nibble sequencing, then CPU writes override
    always_comb begin
        state_nx = state;
        addr_nx  = rom_addr;
        end_nx   = end_addr;
        byte_nx  = byte_q;
        dec_en   = 1'b0;
        dec_clr  = 1'b0;
        nibble_c = rom_data[7:4];

        if (tick_c) begin
            case (state)
                ST_HIGH: begin
                    if (rom_addr >= end_addr) begin
                        state_nx = ST_IDLE;
                        dec_clr  = 1'b1;
                    end else if (rom_ok) begin
                        byte_nx  = rom_data;
                        dec_en   = 1'b1;
                        state_nx = ST_LOW;
                    end
                end
                ST_LOW: begin
                    nibble_c = byte_q[3:0];
                    dec_en   = 1'b1;
                    addr_nx  = rom_addr + ADDR_W'(1);
                    state_nx = ST_HIGH;
                end
                default: ;
            endcase
        end

        if (wr_c) begin
            case (cpu_AB)
                REG_START: begin
                    state_nx = ST_HIGH;
                    dec_clr  = 1'b0;
                end
                REG_END:  end_nx  = wr_addr_c;
                REG_ADDR: addr_nx = wr_addr_c;
                REG_STOP: begin
                    state_nx = ST_IDLE;
                    dec_clr  = 1'b1;
                    dec_en   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Player registers and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            end_addr <= '0;
            byte_q   <= '0;
            rom_cs   <= 1'b0;
        end else begin
            state    <= state_nx;
            rom_addr <= addr_nx;
            end_addr <= end_nx;
            byte_q   <= byte_nx;
            rom_cs   <= (state_nx != ST_IDLE);
        end
    end

    // Sample-rate divider: one tick per 48 cen_oki pulses, free-running
    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= '0;
            sample <= 1'b0;
        end else begin
            sample <= tick_c;
            if (cen_oki) div <= (div == DIV_W'(DIV_WRAP)) ? '0 : div + DIV_W'(1);
        end
    end

    dd_adpcm_decoder u_decoder (
        .clk    (clk),
        .rst    (rst),
        .clr    (dec_clr),
        .en     (dec_en),
        .nibble (nibble_c),
        .snd    (dec_snd)
    );

    // Output gating of the registered decoder signal
`ifdef DD_ADPCM_MUTE_ON_STOP_EN
    assign snd = rom_cs ? dec_snd : '0;
`else
    assign snd = dec_snd;
`endif

endmodule

// File: tb/tb_dd_adpcm_player.sv
// Scoreboard bench for dd_adpcm_player with a tick-level behavioural model.
module tb_dd_adpcm_player;

    logic               clk = 1'b0;
    logic               rst;
    logic               cpu_cen;
    logic               cen_oki;
    logic [7:0]         cpu_dout;
    logic [1:0]         cpu_AB;
    logic               cs;
    logic [15:0]        rom_addr;
    logic               rom_cs;
    logic [7:0]         rom_data;
    logic               rom_ok;
    logic signed [11:0] snd;
    logic               sample;

    logic [7:0] rom [0:65535];
    assign rom_data = rom[rom_addr];

    dd_adpcm_player dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_cen  (cpu_cen),
        .cen_oki  (cen_oki),
        .cpu_dout (cpu_dout),
        .cpu_AB   (cpu_AB),
        .cs       (cs),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .snd      (snd),
        .sample   (sample)
    );

    always #5 clk = ~clk;

    int unsigned STEP_T [0:48] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
        107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,
        876,963,1060,1166,1282,1411,1552};
    int ADJ_T [0:7] = '{-1,-1,-1,-1,2,4,6,8};

    typedef struct {
        int snd;
        int cs;
        int addr;
        int due;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_n = 0;
    int   oki_cnt = 0;

    // reference model state
    int         m_sig, m_idx, m_addr, m_end;
    bit         m_play, m_hi;
    logic [7:0] m_byte;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void m_decode(input int n);
        int s, d;
        s = int'(STEP_T[m_idx]);
        d = s / 8;
        if (n & 1) d += s / 4;
        if (n & 2) d += s / 2;
        if (n & 4) d += s;
        if (n & 8) m_sig -= d; else m_sig += d;
        if (m_sig > 2047)  m_sig = 2047;
        if (m_sig < -2048) m_sig = -2048;
        m_idx += ADJ_T[n & 7];
        if (m_idx < 0)  m_idx = 0;
        if (m_idx > 48) m_idx = 48;
    endfunction

    function automatic int m_snd();
`ifdef DD_ADPCM_MUTE_ON_STOP_EN
        return m_play ? m_sig : 0;
`else
        return m_sig;
`endif
    endfunction

    function automatic void m_tick();
        exp_t e;
        if (m_play) begin
            if (m_hi) begin
                if (m_addr >= m_end) begin
                    m_play = 0;
                    m_sig  = 0;
                    m_idx  = 0;
                end else if (rom_ok) begin
                    m_byte = rom[m_addr];
                    m_decode(int'(m_byte[7:4]));
                    m_hi = 0;
                end
            end else begin
                m_decode(int'(m_byte[3:0]));
                m_addr = (m_addr + 1) & 16'hFFFF;
                m_hi = 1;
            end
        end
        e.snd  = m_snd();
        e.cs   = int'(m_play);
        e.addr = m_addr;
        e.due  = cyc_n + 1;
        q.push_back(e);
    endfunction

    // One clock of stimulus; the 48th cen_oki of a period is a sample tick
    task automatic cyc(input logic c);
        @(negedge clk);
        cs      = 1'b0;
        cpu_cen = 1'b1;
        cen_oki = c;
        if (c) begin
            if (oki_cnt == 47) begin
                oki_cnt = 0;
                m_tick();
            end else begin
                oki_cnt++;
            end
        end
    endtask

    task automatic wr(input logic [1:0] ab, input logic [7:0] d, input logic en);
        @(negedge clk);
        cen_oki  = 1'b0;
        cs       = 1'b1;
        cpu_cen  = en;
        cpu_AB   = ab;
        cpu_dout = d;
        if (en) begin
            case (ab)
                2'd0: begin m_play = 1; m_hi = 1; end
                2'd1: m_end  = int'({d[6:0], 9'd0});
                2'd2: m_addr = int'({d[6:0], 9'd0});
                default: begin m_play = 0; m_sig = 0; m_idx = 0; end
            endcase
        end
    endtask

    // Run cen_oki pulses with random gaps until one sample tick is issued
    task automatic run_tick(input int gap_max, input logic ok);
        bit done;
        done = 0;
        while (!done) begin
            repeat ($urandom_range(0, gap_max)) cyc(1'b0);
            if (oki_cnt == 47) begin
                rom_ok = ok;
                done = 1;
            end
            cyc(1'b1);
        end
    endtask

    // Monitor: compare DUT state on every sample pulse against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sample) begin
                if (q.size() == 0) begin
                    chk("sample_spurious", int'(sample), 0);
                end else begin
                    e = q.pop_front();
                    chk("sample_time", cyc_n, e.due);
                    chk("snd", int'(snd), e.snd);
                    chk("rom_cs", int'(rom_cs), e.cs);
                    chk("rom_addr", int'(rom_addr), e.addr);
                end
            end else if (q.size() > 0 && q[0].due <= cyc_n) begin
                e = q.pop_front();
                chk("sample_missing", int'(sample), 1);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, s0;
        for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
        rom[0] = 8'h78;
        for (int i = 1; i <= 20; i++)  rom[i] = 8'h77;
        for (int i = 21; i <= 40; i++) rom[i] = 8'hFF;

        rst = 1'b1; cpu_cen = 1'b1; cen_oki = 1'b0; cpu_dout = '0;
        cpu_AB = '0; cs = 1'b0; rom_ok = 1'b1;
        m_sig = 0; m_idx = 0; m_addr = 0; m_end = 0; m_play = 0; m_hi = 1; m_byte = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        cyc(1'b0);
        chk("reset_rom_cs", int'(rom_cs), 0);
        chk("reset_snd", int'(snd), 0);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_sample", int'(sample), 0);

        // idle ticks: sample still pulses
        repeat (2) run_tick(1, 1'b1);

        // first byte 0x78 from reset decoder state
        wr(2'd2, 8'h00, 1'b1);
        wr(2'd1, 8'h01, 1'b1);
        wr(2'd0, 8'h5A, 1'b1);
        cyc(1'b0);
        chk("start_rom_cs", int'(rom_cs), 1);
        run_tick(1, 1'b1); cyc(1'b0);
        chk("first_nibble_snd", int'(snd), 30);
        run_tick(1, 1'b1); cyc(1'b0);
        chk("second_nibble_snd", int'(snd), 26);

        // positive then negative saturation
        repeat (40) run_tick(1, 1'b1);
        cyc(1'b0);
        chk("sat_pos_snd", int'(snd), 2047);
        repeat (40) run_tick(1, 1'b1);
        cyc(1'b0);
        chk("sat_neg_snd", int'(snd), -2048);

        // rom_ok low on a high-phase tick stalls the decoder
        if (!m_hi) run_tick(1, 1'b1);
        a0 = m_addr; s0 = m_sig;
        run_tick(1, 1'b0); cyc(1'b0);
        chk("stall_rom_addr", int'(rom_addr), a0);
        chk("stall_snd", int'(snd), s0);
        run_tick(1, 1'b1);

        // randomized playback with relocations, restarts and gated writes
        wr(2'd1, 8'h7F, 1'b1);
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r == 0)      wr(2'd2, 8'($urandom_range(0, 126)), 1'b1);
            else if (r == 1) wr(2'd0, 8'($urandom), 1'b1);
            else if (r == 2) wr(2'd3, 8'($urandom), 1'b0);
            run_tick(1, logic'($urandom_range(0, 3) != 0));
        end

        // stop mid-sample
        wr(2'd0, 8'h00, 1'b1);
        repeat (3) run_tick(1, 1'b1);
        wr(2'd3, 8'h00, 1'b1);
        cyc(1'b0);
        chk("stop_rom_cs", int'(rom_cs), 0);
        chk("stop_snd", int'(snd), 0);
        repeat (2) run_tick(1, 1'b1);

        // full 512-byte sample ending at the end address
        wr(2'd2, 8'h01, 1'b1);
        wr(2'd1, 8'h02, 1'b1);
        wr(2'd0, 8'($urandom), 1'b1);
        cyc(1'b0);
        chk("long_start_rom_cs", int'(rom_cs), 1);
        chk("long_start_rom_addr", int'(rom_addr), 16'h0200);
        repeat (1024) run_tick(0, 1'b1);
        cyc(1'b0);
        chk("long_end_rom_addr", int'(rom_addr), 16'h0400);
        chk("long_end_busy", int'(rom_cs), 1);
        run_tick(0, 1'b1); cyc(1'b0);
        chk("long_stop_rom_cs", int'(rom_cs), 0);
        chk("long_stop_snd", int'(snd), 0);

        repeat (3) cyc(1'b0);
        chk("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
